// File: rtl/logic_sweep_controller_pkg.sv
// Shared encodings for the truth-table sweep controller.
// Holds the state encoding and the default golden table for z = (a&b) | ((c^d)&~e).
package logic_sweep_controller_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SETTLE_ENC = 2'd1;
    localparam logic [1:0] ST_SAMPLE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE_ENC,
        SETTLE = ST_SETTLE_ENC,
        SAMPLE = ST_SAMPLE_ENC,
        DONE   = ST_DONE_ENC
    } sweep_state_t;

    // Bit i is z for {a,b,c,d,e} = i, a being the MSB.
    localparam logic [31:0] TT_GOLDEN_AB_CXD_NE = 32'hFF141414;

endpackage

// File: rtl/logic_sweep_controller.sv
// Sweeps a 5-input combinational block through all 32 codes and captures its truth table.
// Latency: 32*(SETTLE_CYCLES+1) cycles from accepting start to the done pulse.
// Backpressure: none; start is ignored while busy, abort cancels a running sweep.
module logic_sweep_controller
    import logic_sweep_controller_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [31:0] GOLDEN        = TT_GOLDEN_AB_CXD_NE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic        z,
    output logic [4:0]  stim,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        pass,
    output logic        fail_valid,
    output logic [4:0]  first_fail
);

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    sweep_state_t state, state_nxt;
    logic [4:0]   idx;
    logic [7:0]   cnt;
    logic [31:0]  result_cap;
    logic         mismatch;

    always_comb begin
        state_nxt       = state;
        result_cap      = result;
        result_cap[idx] = z;
        mismatch        = (z != GOLDEN[idx]);
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  begin
                if (abort)                 state_nxt = IDLE;
                else if (cnt == CNT_LAST)  state_nxt = SAMPLE;
            end
            SAMPLE:  begin
                if (abort)                 state_nxt = IDLE;
                else if (idx == 5'd31)     state_nxt = DONE;
                else                       state_nxt = SETTLE;
            end
            DONE:    state_nxt = start ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            idx        <= 5'd0;
            cnt        <= 8'd0;
            stim       <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'd0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            first_fail <= 5'd0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= 5'd0;
                        cnt        <= 8'd0;
                        stim       <= 5'd0;
                        busy       <= 1'b1;
                        result     <= 32'd0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        first_fail <= 5'd0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        busy <= 1'b0;
                        pass <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    // Abort takes priority: the code being sampled is never captured.
                    if (abort) begin
                        busy <= 1'b0;
                        pass <= 1'b0;
                    end else begin
                        result <= result_cap;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            first_fail <= idx;
                        end
                        if (idx == 5'd31) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (result_cap == GOLDEN);
                        end else begin
                            idx  <= idx + 5'd1;
                            stim <= idx + 5'd1;
                            cnt  <= 8'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
